rr_handshake_arbiter: RTL and testbench

- Round-robin packet arbiter sharing one ready/valid datapath input between N_REQ requesters, such as the three-lane handshake array feeding the RTL core.
- Grants whole packets: it locks to the winner until that requester's last beat transfers.
- Drives the shared input through one registered output stage, with full throughput and 1-cycle latency.

---
 rtl/rr_arb_pkg.sv | 13 +
 rtl/rr_arb_pick.sv | 35 +++
 rtl/rr_handshake_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rr_handshake_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and helpers for the round-robin handshake arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  localparam int N_REQ_DEF = 3;
  localparam int WIDTH_DEF = 4;

  function automatic int src_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority picker: first requester after i_ptr (wrapping) wins.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SRC_W = src_width(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);

  // Search ptr+1, ptr+2, ... modulo N_REQ; the first set request takes the grant.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_any = 1'b1;
        o_idx = SRC_W'((int'(i_ptr) + k) % N_REQ);
      end else begin
        o_any = o_any;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end else begin
      o_gnt = '0;
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin packet arbiter feeding one registered ready/valid output stage.
// Optional per-requester grant counters are enabled with macro RR_ARB_GRANT_CNT_EN.
module rr_handshake_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = 8,
  localparam int SRC_W    = src_width(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_last
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [N_REQ*CNT_WIDTH-1:0] grant_cnt
`endif
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [SRC_W-1:0] r_owner;
  logic [SRC_W-1:0] w_owner_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0] r_out_src;
  logic             r_out_last;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [SRC_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_load;
  logic             w_xfer;
  logic [SRC_W-1:0] w_xfer_idx;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;

  rr_arb_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_load     = !r_out_valid || out_ready;
  assign w_xfer     = |(req_valid & req_ready);
  assign w_xfer_idx = (r_state == LOCKED) ? r_owner : w_pick_idx;
  assign w_sel_last = req_last[w_xfer_idx];
  assign w_sel_data = req_data[w_xfer_idx*WIDTH +: WIDTH];

  // Grant decode: the owner keeps its ready while locked even with valid low.
  always_comb begin
    req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_load && w_pick_any) begin
          req_ready = w_pick_gnt;
        end else begin
          req_ready = '0;
        end
      end
      LOCKED: begin
        if (w_load) begin
          req_ready[r_owner] = 1'b1;
        end else begin
          req_ready = '0;
        end
      end
      default: req_ready = '0;
    endcase
  end

  // Next-state logic for the packet lock and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_ptr_nxt = w_pick_idx;
          if (!w_sel_last) begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if (w_xfer && w_sel_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= IDLE;
      r_ptr   <= SRC_W'(N_REQ - 1);
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Output stage: load on any requester transfer, empty on drain, otherwise hold.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_xfer_idx;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

`ifdef RR_ARB_GRANT_CNT_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_cnt;

    // Count first-beat grants taken from IDLE, saturating at all-ones.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        r_cnt <= '0;
      end else if (r_state == IDLE && w_xfer && w_pick_idx == SRC_W'(gi) && r_cnt != {CNT_WIDTH{1'b1}}) begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end

    assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end
`else
  // Grant counters not built.
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed table-driven bench for rr_handshake_arbiter (N_REQ=3, WIDTH=4).
module tb_rr_handshake_arbiter;

  logic        CLK;
  logic        ASYNCRESETN;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [11:0] req_data;
  logic [2:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [23:0] grant_cnt;
`endif

  int n_chk;
  int n_err;

  rr_handshake_arbiter #(.N_REQ(3), .WIDTH(4), .CNT_WIDTH(8)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_last    (out_last)
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  l;
    logic [11:0] d;
    logic        ordy;
    logic [2:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_src;
    logic [3:0]  e_dat;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic [11:0] d, input logic r);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    out_ready = r;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    ASYNCRESETN = 1'b0;
    drive(3'b000, 3'b000, 12'h000, 1'b1);

    // Three 1-beat requesters rotating 0,1,2,...
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b001, 1'b0, 2'd0, 4'h0, 1'b0});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b010, 1'b1, 2'd0, 4'h1, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b100, 1'b1, 2'd1, 4'h2, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b001, 1'b1, 2'd2, 4'h3, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b010, 1'b1, 2'd0, 4'h1, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b100, 1'b1, 2'd1, 4'h2, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b001, 1'b1, 2'd2, 4'h3, 1'b1});
    // Req1 sends A,B,C while req0/req2 stay valid.
    vecs.push_back('{3'b111, 3'b101, 12'h3A1, 1'b1, 3'b010, 1'b1, 2'd0, 4'h1, 1'b1});
    vecs.push_back('{3'b111, 3'b101, 12'h3B1, 1'b1, 3'b010, 1'b1, 2'd1, 4'hA, 1'b0});
    vecs.push_back('{3'b111, 3'b111, 12'h3C1, 1'b1, 3'b010, 1'b1, 2'd1, 4'hB, 1'b0});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b100, 1'b1, 2'd1, 4'hC, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b001, 1'b1, 2'd2, 4'h3, 1'b1});
    // Req0 locks, drops valid for 2 cycles with req2 waiting, then finishes.
    vecs.push_back('{3'b001, 3'b000, 12'h325, 1'b1, 3'b001, 1'b1, 2'd0, 4'h1, 1'b1});
    vecs.push_back('{3'b100, 3'b100, 12'h321, 1'b1, 3'b001, 1'b1, 2'd0, 4'h5, 1'b0});
    vecs.push_back('{3'b100, 3'b100, 12'h321, 1'b1, 3'b001, 1'b0, 2'd0, 4'h5, 1'b0});
    vecs.push_back('{3'b101, 3'b101, 12'h326, 1'b1, 3'b001, 1'b0, 2'd0, 4'h5, 1'b0});
    vecs.push_back('{3'b100, 3'b100, 12'h321, 1'b1, 3'b100, 1'b1, 2'd0, 4'h6, 1'b1});
    // Back-pressure for 3 cycles, then resume with req0.
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b0, 3'b000, 1'b1, 2'd2, 4'h3, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b0, 3'b000, 1'b1, 2'd2, 4'h3, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b0, 3'b000, 1'b1, 2'd2, 4'h3, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b001, 1'b1, 2'd2, 4'h3, 1'b1});
    vecs.push_back('{3'b111, 3'b111, 12'h321, 1'b1, 3'b010, 1'b1, 2'd0, 4'h1, 1'b1});

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", -1, 32'(out_valid), 32'd0);
    chk("rst_out_data",  -1, 32'(out_data),  32'd0);
    chk("rst_out_src",   -1, 32'(out_src),   32'd0);
    chk("rst_out_last",  -1, 32'(out_last),  32'd0);
    ASYNCRESETN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK);
      #1;
      drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].ordy);
      @(negedge CLK);
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].e_rdy));
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
      chk("out_src",   i, 32'(out_src),   32'(vecs[i].e_src));
      chk("out_data",  i, 32'(out_data),  32'(vecs[i].e_dat));
      chk("out_last",  i, 32'(out_last),  32'(vecs[i].e_last));
    end

    // Reset in the middle of a req1 packet.
    @(posedge CLK);
    #1;
    drive(3'b010, 3'b000, 12'h371, 1'b1);
    @(negedge CLK);
    chk("mid_pkt_ready", 100, 32'(req_ready), 32'b010);
    @(posedge CLK);
    #2;
    chk("mid_pkt_out_valid", 101, 32'(out_valid), 32'd1);
    ASYNCRESETN = 1'b0;
    #1;
    chk("async_rst_out_valid", 102, 32'(out_valid), 32'd0);
    chk("async_rst_out_data",  102, 32'(out_data),  32'd0);
    drive(3'b001, 3'b001, 12'h321, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    chk("post_rst_ready", 103, 32'(req_ready), 32'b001);
    @(posedge CLK);
    #1;
    chk("post_rst_out_valid", 104, 32'(out_valid), 32'd1);
    chk("post_rst_out_src",   104, 32'(out_src),   32'd0);

`ifdef RR_ARB_GRANT_CNT_EN
    // One grant to req0 already counted; 299 more saturate its counter.
    repeat (299) @(posedge CLK);
    #1;
    chk("grant_cnt0", 200, 32'(grant_cnt[7:0]),   32'd255);
    chk("grant_cnt1", 200, 32'(grant_cnt[15:8]),  32'd0);
    chk("grant_cnt2", 200, 32'(grant_cnt[23:16]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
